// File: rtl/fft_butterfly_scheduler.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly read/twiddle addresses and
// delayed write-back addresses, with drain bubbles between stages. Optional IFFT: FFT_INVERSE_EN.
module fft_butterfly_scheduler #(
  parameter int LOG2N   = 3,
  parameter int RD_LAT  = 1,
  parameter int MAU_LAT = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
`ifdef FFT_INVERSE_EN
  input  logic             Inverse,
  output logic             TwConj,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [LOG2N-1:0] Stage,
  output logic             RdEn,
  output logic [LOG2N-1:0] RdAddrA,
  output logic [LOG2N-1:0] RdAddrB,
  output logic [LOG2N-2:0] TwAddr,
  output logic             WrEn,
  output logic [LOG2N-1:0] WrAddrA,
  output logic [LOG2N-1:0] WrAddrB
);

  localparam int PIPE_LAT = RD_LAT + MAU_LAT;
  localparam int BW       = LOG2N - 1;
  localparam int DW       = $clog2(PIPE_LAT + 1);

  localparam logic [BW-1:0]    BLAST = '1;
  localparam logic [LOG2N-1:0] SLAST = LOG2N'(LOG2N - 1);
  localparam logic [DW-1:0]    DLAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [LOG2N-1:0] s, s_n;
  logic [BW-1:0]    b, b_n;
  logic [DW-1:0]    dcnt, dcnt_n;

`ifdef FFT_INVERSE_EN
  logic inv, inv_n;
`endif

  logic [LOG2N-1:0] bx, span, pos, grp, addr_a, addr_b;
  logic [BW-1:0]    tw;

  logic             pv [PIPE_LAT];
  logic [LOG2N-1:0] pa [PIPE_LAT];
  logic [LOG2N-1:0] pb [PIPE_LAT];

  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    dcnt_n  = dcnt;
`ifdef FFT_INVERSE_EN
    inv_n   = inv;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          state_n = ISSUE;
          s_n     = '0;
          b_n     = '0;
          dcnt_n  = '0;
`ifdef FFT_INVERSE_EN
          inv_n   = Inverse;
`endif
        end
      end
      ISSUE: begin
        if (b == BLAST) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          b_n = b + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DLAST) begin
          if (s == SLAST) begin
            state_n = FIN;
          end else begin
            state_n = ISSUE;
            s_n     = s + 1'b1;
            b_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      FIN: begin
        state_n = IDLE;
        s_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Butterfly b of stage s: group grp spans 2*span entries, pair offset pos.
  always_comb begin
    bx     = {1'b0, b};
    span   = LOG2N'(1) << s;
    pos    = bx & (span - 1'b1);
    grp    = bx >> s;
    addr_a = (grp << (s + 1'b1)) | pos;
    addr_b = addr_a + span;
    tw     = pos[BW-1:0] << (SLAST - s);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      dcnt  <= '0;
`ifdef FFT_INVERSE_EN
      inv   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s     <= s_n;
      b     <= b_n;
      dcnt  <= dcnt_n;
`ifdef FFT_INVERSE_EN
      inv   <= inv_n;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RdEn    <= 1'b0;
      RdAddrA <= '0;
      RdAddrB <= '0;
      TwAddr  <= '0;
      Stage   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
`ifdef FFT_INVERSE_EN
      TwConj  <= 1'b0;
`endif
    end else begin
      RdEn    <= (state == ISSUE);
      RdAddrA <= addr_a;
      RdAddrB <= addr_b;
      TwAddr  <= tw;
      Stage   <= s;
      Busy    <= (state == ISSUE) || (state == DRAIN);
      Done    <= (state == FIN);
`ifdef FFT_INVERSE_EN
      TwConj  <= (state == ISSUE) && inv;
`endif
    end
  end

  // Write-back delay line fed from the registered read strobe; its last tap is the write port.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= RdEn;
      pa[0] <= RdAddrA;
      pb[0] <= RdAddrB;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign WrEn    = pv[PIPE_LAT-1];
  assign WrAddrA = pa[PIPE_LAT-1];
  assign WrAddrB = pb[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Randomized bench for fft_butterfly_scheduler against a per-cycle schedule model
// derived from the stage/butterfly arithmetic; TwConj checked when FFT_INVERSE_EN is set.
module tb_fft_butterfly_scheduler;

  localparam int LOG2N   = 3;
  localparam int RD_LAT  = 1;
  localparam int MAU_LAT = 2;
  localparam int N       = 1 << LOG2N;
  localparam int H       = N / 2;
  localparam int P       = RD_LAT + MAU_LAT;
  localparam int SL      = H + P;
  localparam int NC      = LOG2N * SL + 2;

  logic             Clk, Rst, Start, Inverse;
  logic             Busy, Done, RdEn, WrEn;
  logic [LOG2N-1:0] Stage, RdAddrA, RdAddrB, WrAddrA, WrAddrB;
  logic [LOG2N-2:0] TwAddr;
`ifdef FFT_INVERSE_EN
  logic             TwConj;
`endif

  fft_butterfly_scheduler #(
    .LOG2N  (LOG2N),
    .RD_LAT (RD_LAT),
    .MAU_LAT(MAU_LAT)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
`ifdef FFT_INVERSE_EN
    .Inverse(Inverse),
    .TwConj (TwConj),
`endif
    .Busy   (Busy),
    .Done   (Done),
    .Stage  (Stage),
    .RdEn   (RdEn),
    .RdAddrA(RdAddrA),
    .RdAddrB(RdAddrB),
    .TwAddr (TwAddr),
    .WrEn   (WrEn),
    .WrAddrA(WrAddrA),
    .WrAddrB(WrAddrB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  int e_rd[NC], e_a[NC], e_b[NC], e_tw[NC];
  int e_wr[NC], e_wa[NC], e_wb[NC];
  int e_busy[NC], e_done[NC], e_stage[NC];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycle c of a run counts edges from the one that sampled Start (c = 0).
  task automatic build_model();
    int c, span, a;
    for (int i = 0; i < NC; i++) begin
      e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0;
      e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_stage[i] = -1;
    end
    for (int s = 0; s < LOG2N; s++) begin
      span = 1 << s;
      for (int b = 0; b < H; b++) begin
        c = 1 + s * SL + b;
        a = (b / span) * 2 * span + (b % span);
        e_rd[c] = 1; e_a[c] = a; e_b[c] = a + span;
        e_tw[c] = (b % span) * (H / span);
        e_wr[c + P] = 1; e_wa[c + P] = a; e_wb[c + P] = a + span;
      end
    end
    for (int i = 1; i <= LOG2N * SL; i++) begin
      e_busy[i]  = 1;
      e_stage[i] = (i - 1) / SL;
    end
    e_done[LOG2N * SL + 1] = 1;
  endtask

  task automatic check_cycle(input int c, input bit inv);
    check($sformatf("busy[c%0d]", c), Busy, e_busy[c]);
    check($sformatf("done[c%0d]", c), Done, e_done[c]);
    check($sformatf("rden[c%0d]", c), RdEn, e_rd[c]);
    check($sformatf("wren[c%0d]", c), WrEn, e_wr[c]);
    if (e_stage[c] >= 0) check($sformatf("stage[c%0d]", c), Stage, e_stage[c]);
    if (e_rd[c] != 0) begin
      check($sformatf("rda[c%0d]", c), RdAddrA, e_a[c]);
      check($sformatf("rdb[c%0d]", c), RdAddrB, e_b[c]);
      check($sformatf("tw[c%0d]", c), TwAddr, e_tw[c]);
    end
    if (e_wr[c] != 0) begin
      check($sformatf("wra[c%0d]", c), WrAddrA, e_wa[c]);
      check($sformatf("wrb[c%0d]", c), WrAddrB, e_wb[c]);
    end
`ifdef FFT_INVERSE_EN
    check($sformatf("twconj[c%0d]", c), TwConj, (e_rd[c] != 0) ? int'(inv) : 0);
`else
    if (inv) begin end
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, Busy, 0);
    check({tag, ".done"}, Done, 0);
    check({tag, ".rden"}, RdEn, 0);
    check({tag, ".wren"}, WrEn, 0);
`ifdef FFT_INVERSE_EN
    check({tag, ".twconj"}, TwConj, 0);
`endif
  endtask

  // Start must already be 1 ahead of edge 0; chain leaves it high to restart after Done.
  task automatic do_run(input bit held, input bit chain, input int abort_at, input bit inv);
    for (int c = 0; c < NC; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (c == 0) Start = held;
      if (c == NC - 1) Start = chain;
      check_cycle(c, inv);
      if (c == abort_at) begin
        Rst = 1'b1;
        #1;
        check("abort.rden", RdEn, 0);
        check("abort.wren", WrEn, 0);
        check("abort.busy", Busy, 0);
        check("abort.done", Done, 0);
        @(posedge Clk);
        @(negedge Clk);
        Rst   = 1'b0;
        Start = 1'b0;
        for (int k = 0; k < SL * LOG2N; k++) begin
          @(posedge Clk);
          @(negedge Clk);
          check_idle("post_abort");
        end
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, gap;
    bit inv;
    build_model();
    Rst = 1'b1; Start = 1'b0; Inverse = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst.busy", Busy, 0);
    check("rst.done", Done, 0);
    check("rst.rden", RdEn, 0);
    check("rst.wren", WrEn, 0);
    check("rst.stage", Stage, 0);
    check("rst.rda", RdAddrA, 0);
    check("rst.rdb", RdAddrB, 0);
    check("rst.tw", TwAddr, 0);
    check("rst.wra", WrAddrA, 0);
    check("rst.wrb", WrAddrB, 0);
`ifdef FFT_INVERSE_EN
    check("rst.twconj", TwConj, 0);
`endif
    Rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_idle("idle_after_rst");
    end

    for (int t = 0; t < 12; t++) begin
      mode = (t < 4) ? t : int'($urandom_range(0, 3));
      inv  = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      gap  = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) begin
        @(posedge Clk);
        @(negedge Clk);
        check_idle("gap");
      end
      Inverse = inv;
      Start   = 1'b1;
      case (mode)
        1: begin
          do_run(1'b1, 1'b1, -1, inv);
          do_run(1'b1, 1'b0, -1, inv);
        end
        2: do_run(1'b0, 1'b0, (t == 2) ? 10 : int'($urandom_range(1, NC - 2)), inv);
        default: do_run(1'b0, 1'b0, -1, inv);
      endcase
      Inverse = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
